inv_arb: RTL

Round-robin arbiter sharing one `invN` inverter datapath among `NREQ` requesters. Each requester offers a `WIDTH`-bit word over a valid/ready handshake. The block grants one requester per cycle, registers the inverted word together with the winner's index, and presents it on a single response channel with backpressure. It sits between several producer blocks and a single consumer that needs tagged inverted data.

---
 rtl/inv_arb_pkg.sv | 22 ++
 rtl/invN.sv | 11 +
 rtl/rr_pick.sv | 31 +++
 rtl/inv_arb.sv | 81 ++++++++
 4 files changed

// File: rtl/inv_arb_pkg.sv
// Shared defaults, index-width helper and response-register state encoding
// for the inv_arb slice.
package inv_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  // Constant-foldable ceiling log2, used for index widths in parameter lists
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Response register occupancy; FULL is exactly o_rsp_valid
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/invN.sv
// Parameterised bitwise inverter datapath shared by all requesters.
module invN #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set valid bit at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int unsigned k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!any && valid[k]) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/inv_arb.sv
// Round-robin arbiter sharing one inverter among NREQ requesters, with a
// single tagged output register and pass-through drain.
module inv_arb
  import inv_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = clog2(NREQ),
  parameter int CNTW  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  output logic                  o_rsp_valid,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic [IDW-1:0]        o_rsp_id,
  input  logic                  i_rsp_ready,
  output logic [CNTW-1:0]       o_cnt
);

  rsp_state_t       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_idx;
  logic [NREQ-1:0]  win_oh;
  logic             win_any;
  logic             can_accept;
  logic             req_hs;
  logic             rsp_hs;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] inv_data;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid  (i_req_valid),
    .ptr    (ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign win_data = i_req_data[int'(win_idx)*WIDTH +: WIDTH];

  invN #(
    .WIDTH (WIDTH)
  ) u_inv (
    .a (win_data),
    .y (inv_data)
  );

  assign o_rsp_valid = (state == FULL);
  // A draining response frees the register in the same cycle
  assign can_accept  = !o_rsp_valid || i_rsp_ready;
  assign o_req_ready = can_accept ? win_oh : '0;
  assign req_hs      = can_accept && win_any;
  assign rsp_hs      = o_rsp_valid && i_rsp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= EMPTY;
      o_rsp_data <= '0;
      o_rsp_id   <= '0;
      ptr        <= '0;
      o_cnt      <= '0;
    end else begin
      if (req_hs) begin
        state      <= FULL;
        o_rsp_data <= inv_data;
        o_rsp_id   <= win_idx;
        ptr        <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (rsp_hs) begin
        state <= EMPTY;
      end
      if (rsp_hs) o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule
